// File: rtl/if_id_latch.sv
// =============================================================================
// Module   : if_id_latch
// Brief    : IF/ID pipeline register. It holds the decode slot on a hazard and
//            injects bubbles on a flush or an instruction-memory stall. It also
//            freezes fetch once a HALT reaches decode.
//            Optional consecutive-stall watchdog: define IFID_STALL_WDOG_EN.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_id_latch #(
    parameter int                INST_W    = 16,
    parameter logic [INST_W-1:0] NOP_INST  = 16'h0800,
    parameter int                STALL_MAX = 3,
    parameter int                CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst_if,
    input  logic [INST_W-1:0] pcp2_if,
    input  logic              imem_stall,
    input  logic              sendNOP,
    input  logic              flush,
    output logic [INST_W-1:0] inst_id,
    output logic [INST_W-1:0] pcp2_id,
    output logic              nop_id,
    output logic              pc_hold,
    output logic              halted,
    output logic              stall_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    state_t            r_state;
    logic [INST_W-1:0] r_inst_id;
    logic [INST_W-1:0] r_pcp2_id;
    logic              r_nop_id;
    logic              r_halted;

    logic              w_hazard;
    logic              w_halt_det;
    logic              w_stall_edge;

    // A bubble in decode can never raise a hazard, so gate with the valid flag.
    assign w_hazard     = ~sendNOP & r_nop_id;
    assign w_halt_det   = (r_state != ST_HALT) & r_nop_id
                        & (r_inst_id[INST_W-1 -: 5] == 5'b00000);
    assign w_stall_edge = ~flush & ~w_halt_det & w_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_inst_id <= NOP_INST;
            r_pcp2_id <= '0;
            r_nop_id  <= 1'b0;
            r_halted  <= 1'b0;
        end else if (flush) begin
            r_state   <= ST_RUN;
            r_inst_id <= NOP_INST;
            r_nop_id  <= 1'b0;
            r_halted  <= 1'b0;
        end else if (w_halt_det) begin
            r_state   <= ST_HALT;
            r_nop_id  <= 1'b0;
            r_halted  <= 1'b1;
        end else if (r_state == ST_HALT) begin
            r_nop_id  <= 1'b0;
        end else if (w_stall_edge) begin
            r_state   <= ST_STALL;
        end else begin
            r_state   <= ST_RUN;
            r_pcp2_id <= pcp2_if;
            if (imem_stall) begin
                r_inst_id <= NOP_INST;
                r_nop_id  <= 1'b0;
            end else begin
                r_inst_id <= inst_if;
                r_nop_id  <= 1'b1;
            end
        end
    end

    // A flush redirects fetch, so it must never be blocked by a hold term.
    assign pc_hold = ~flush & (~sendNOP | imem_stall | (r_state == ST_HALT));

    assign inst_id = r_inst_id;
    assign pcp2_id = r_pcp2_id;
    assign nop_id  = r_nop_id;
    assign halted  = r_halted;

`ifdef IFID_STALL_WDOG_EN
    localparam logic [CNT_W-1:0] c_cnt_sat   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_stall_max = CNT_W'(STALL_MAX);

    logic [CNT_W-1:0] r_count;
    logic             r_stall_err;
    logic             w_wdog_trip;

    assign w_wdog_trip = w_stall_edge & (r_count >= c_stall_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_stall_err <= 1'b0;
        end else if (w_stall_edge) begin
            if (r_count != c_cnt_sat) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_wdog_trip) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_count <= '0;
        end
    end

    assign stall_err = r_stall_err;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_wdog_trip && !r_stall_err) begin
            $display("WARNING if_id_latch: hazard stall exceeded %0d cycles at %0t", STALL_MAX, $time);
        end
    end
`endif
`else
    assign stall_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_latch.sv
// =============================================================================
// Module   : tb_if_id_latch
// Brief    : Scoreboard bench for if_id_latch with directed and random stimulus.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_if_id_latch;

    localparam int          STALL_MAX = 3;
    localparam logic [15:0] NOP       = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst_if = 16'h0, pcp2_if = 16'h0;
    logic        imem_stall = 1'b0, sendNOP = 1'b1, flush = 1'b0;
    logic [15:0] inst_id, pcp2_id;
    logic        nop_id, pc_hold, halted, stall_err;

    int checks = 0;
    int errors = 0;

    if_id_latch dut (
        .clk(clk), .rst(rst), .inst_if(inst_if), .pcp2_if(pcp2_if),
        .imem_stall(imem_stall), .sendNOP(sendNOP), .flush(flush),
        .inst_id(inst_id), .pcp2_id(pcp2_id), .nop_id(nop_id),
        .pc_hold(pc_hold), .halted(halted), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pcp2;
        logic        valid;
        logic        hold;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: what decode holds, whether it is real, and the run of stall edges.
    logic [15:0] m_inst, m_pcp2;
    logic        m_valid, m_halted, m_err;
    int          m_run;

    task automatic model_reset();
        m_inst = NOP; m_pcp2 = 16'h0; m_valid = 1'b0;
        m_halted = 1'b0; m_err = 1'b0; m_run = 0;
    endtask

    task automatic model_edge(input logic [15:0] i, p, input logic ims, snop, fl);
        if (fl) begin
            m_inst = NOP; m_valid = 1'b0; m_halted = 1'b0; m_run = 0;
        end else if (!m_halted && m_valid && m_inst[15:11] == 5'd0) begin
            m_halted = 1'b1; m_valid = 1'b0; m_run = 0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (!snop && m_valid) begin
            m_run = m_run + 1;
`ifdef IFID_STALL_WDOG_EN
            if (m_run > STALL_MAX) m_err = 1'b1;
`endif
        end else begin
            m_run  = 0;
            m_pcp2 = p;
            m_inst = ims ? NOP : i;
            m_valid = !ims;
        end
    endtask

    task automatic step(input logic r, input logic [15:0] i, p, input logic ims, snop, fl);
        exp_t e;
        @(posedge clk); #1;
        rst = r; inst_if = i; pcp2_if = p; imem_stall = ims; sendNOP = snop; flush = fl;
        if (r) model_reset();
        e.inst = m_inst; e.pcp2 = m_pcp2; e.valid = m_valid;
        e.halted = m_halted; e.err = m_err;
        e.hold = !fl && (!snop || ims || m_halted);
        exp_q.push_back(e);
        if (!r) model_edge(i, p, ims, snop, fl);
    endtask

    task automatic load(input logic [15:0] i, p);
        step(1'b0, i, p, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("inst_id",   inst_id,          e.inst);
                chk("pcp2_id",   pcp2_id,          e.pcp2);
                chk("nop_id",    {15'd0, nop_id},    {15'd0, e.valid});
                chk("pc_hold",   {15'd0, pc_hold},   {15'd0, e.hold});
                chk("halted",    {15'd0, halted},    {15'd0, e.halted});
                chk("stall_err", {15'd0, stall_err}, {15'd0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ri;
        model_reset();
        step(1'b1, 16'h1111, 16'h0002, 1'b0, 1'b1, 1'b0);

        // Hazard hold for two cycles, then a fresh load.
        load(16'hC123, 16'h0102);
        step(1'b0, 16'hAAAA, 16'h0104, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'hBBBB, 16'h0106, 1'b0, 1'b0, 1'b0);
        load(16'h1234, 16'h0108);

        // Flush beats a simultaneous hazard.
        load(16'hC123, 16'h010A);
        step(1'b0, 16'h5555, 16'h010C, 1'b0, 1'b0, 1'b1);
        load(16'h2345, 16'h010E);

        // Instruction-memory stall bubble.
        step(1'b0, 16'h6666, 16'h0010, 1'b1, 1'b1, 1'b0);
        load(16'h3456, 16'h0012);

        // HALT freezes fetch until a flush.
        load(16'h0000, 16'h0014);
        for (int k = 0; k < 11; k++) load(16'h4000 + 16'(k), 16'h0016);
        step(1'b0, 16'h7777, 16'h0020, 1'b0, 1'b1, 1'b1);
        load(16'h4567, 16'h0022);

        // Long hazard run (trips the watchdog when it is built in).
        load(16'hC123, 16'h0024);
        for (int k = 0; k < 4; k++) step(1'b0, 16'h9999, 16'h0026, 1'b0, 1'b0, 1'b0);
        load(16'h5678, 16'h0028);
        load(16'h6789, 16'h002A);

        // Reset mid-stream.
        load(16'hC321, 16'h002C);
        step(1'b1, 16'hDEAD, 16'h002E, 1'b0, 1'b1, 1'b0);
        load(16'h789A, 16'h0030);

        for (int k = 0; k < 300; k++) begin
            ri = 16'($urandom);
            if ($urandom_range(15, 0) == 0) ri[15:11] = 5'd0;
            step(($urandom_range(63, 0) == 0), ri, 16'($urandom),
                 ($urandom_range(5, 0) == 0), ($urandom_range(3, 0) != 0),
                 ($urandom_range(9, 0) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
